// File: rtl/ram_arb_dp.sv
// ram_arb_dp: one block-RAM shared by instruction-fetch (IF) and load/store (D) ports,
// per-cycle arbitration with IF starvation guard; RAM_PARITY_EN adds a stored parity bit and par_err.
module ram_arb_dp #(
   parameter int DATA_W     = 16,
   parameter int ADDR_W     = 12,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata
`ifdef RAM_PARITY_EN
   ,output logic             par_err
`endif
);
`ifdef RAM_PARITY_EN
   localparam int MW = DATA_W + 1;
`else
   localparam int MW = DATA_W;
`endif
   logic [MW-1:0]     mem [2**ADDR_W];
   logic [3:0]        starve_q, starve_d;
   logic              if_win, d_rd, rd;
   logic [ADDR_W-1:0] rd_addr;
   logic [MW-1:0]     rd_word, wr_word;
   logic              if_rvalid_q, d_rvalid_q;
   logic [DATA_W-1:0] if_rdata_q, d_rdata_q;
   always_comb begin
      if_win   = if_req && (!d_req || starve_q == 4'(STARVE_MAX));
      if_gnt   = !rst && if_win;
      d_gnt    = !rst && d_req && !if_win;
      d_rd     = d_gnt && !d_we;
      rd       = if_gnt || d_rd;
      rd_addr  = if_gnt ? if_addr : d_addr;
      starve_d = (if_req && !if_gnt) ? ((starve_q == 4'(STARVE_MAX)) ? starve_q : starve_q + 4'd1) : 4'd0;
   end
   assign rd_word = mem[rd_addr];
`ifdef RAM_PARITY_EN
   assign wr_word = {^d_wdata, d_wdata};
`else
   assign wr_word = d_wdata;
`endif
   always_ff @(posedge clk) begin
      if (d_gnt && d_we) mem[d_addr] <= wr_word;
   end
   // Both ports load from the single read path; each keeps its last word until its next read.
   always_ff @(posedge clk) begin
      if (rst) begin
         starve_q    <= '0;
         if_rvalid_q <= 1'b0;
         d_rvalid_q  <= 1'b0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
      end else begin
         starve_q    <= starve_d;
         if_rvalid_q <= if_gnt;
         d_rvalid_q  <= d_rd;
         if (if_gnt) if_rdata_q <= rd_word[DATA_W-1:0];
         if (d_rd) d_rdata_q <= rd_word[DATA_W-1:0];
      end
   end
`ifdef RAM_PARITY_EN
   logic par_q;
   // Even parity: a clean stored word XORs to zero including its parity bit.
   always_ff @(posedge clk) begin
      if (rst) par_q <= 1'b0;
      else par_q <= rd && (^rd_word);
   end
   assign par_err = par_q;
`endif
   assign if_rvalid = if_rvalid_q;
   assign d_rvalid  = d_rvalid_q;
   assign if_rdata  = if_rdata_q;
   assign d_rdata   = d_rdata_q;
endmodule

// File: tb/tb_ram_arb_dp.sv
// tb_ram_arb_dp: scoreboard bench for ram_arb_dp; parity checks compile in with RAM_PARITY_EN.
module tb_ram_arb_dp;
   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, d_req, d_we;
   logic [11:0] if_addr, d_addr;
   logic [15:0] d_wdata;
   logic        if_gnt, d_gnt, if_rvalid, d_rvalid;
   logic [15:0] if_rdata, d_rdata;
`ifdef RAM_PARITY_EN
   logic        par_err;
`endif
   int          n_chk = 0;
   int          n_fail = 0;
   logic [15:0] mdl [4096];
   bit          bad [4096];
   logic [15:0] ifq [$];
   logic [15:0] dq [$];
   bit          pq [$];
   logic        ig, dg;

   ram_arb_dp #(.DATA_W(16), .ADDR_W(12), .STARVE_MAX(4)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata)
`ifdef RAM_PARITY_EN
      , .par_err(par_err)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // One request cycle: drive, sample grants, record expectations, advance past the edge.
   task automatic cyc(input logic ir, input logic [11:0] ia, input logic dr, input logic dw,
                      input logic [11:0] da, input logic [15:0] wd, output logic g_if, output logic g_d);
      if_req = ir; if_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = wd;
      #1;
      g_if = if_gnt;
      g_d  = d_gnt;
      check("gnt_excl", 32'(g_if & g_d), 32'd0);
      if (g_if) begin ifq.push_back(mdl[ia]); pq.push_back(bad[ia]); end
      if (g_d && !dw) begin dq.push_back(mdl[da]); pq.push_back(bad[da]); end
      if (g_d && dw) begin mdl[da] = wd; bad[da] = 1'b0; end
      @(posedge clk); #1;
   endtask

   always @(negedge clk) begin
      if (if_rvalid) begin
         if (ifq.size() == 0) check("if_unexp_rvalid", 32'd1, 32'd0);
         else check("if_rdata", 32'(if_rdata), 32'(ifq.pop_front()));
      end
      if (d_rvalid) begin
         if (dq.size() == 0) check("d_unexp_rvalid", 32'd1, 32'd0);
         else check("d_rdata", 32'(d_rdata), 32'(dq.pop_front()));
      end
      if ((if_rvalid || d_rvalid) && pq.size() != 0) begin
`ifdef RAM_PARITY_EN
         check("par_err", 32'(par_err), 32'(pq.pop_front()));
`else
         void'(pq.pop_front());
`endif
      end
`ifdef RAM_PARITY_EN
      else if (par_err) check("par_idle", 32'(par_err), 32'd0);
`endif
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      if_addr = '0; d_addr = '0; d_wdata = '0;
      for (int i = 0; i < 4096; i++) begin
         mdl[i] = 16'(i * 16'h9E37 + 3);
         bad[i] = 1'b0;
`ifdef RAM_PARITY_EN
         dut.mem[i] = {^mdl[i], mdl[i]};
`else
         dut.mem[i] = mdl[i];
`endif
      end
      repeat (2) @(posedge clk);
      #1;
      check("rst_if_rvalid", 32'(if_rvalid), 32'd0);
      check("rst_d_rvalid", 32'(d_rvalid), 32'd0);
      check("rst_if_rdata", 32'(if_rdata), 32'd0);
      check("rst_d_rdata", 32'(d_rdata), 32'd0);
      if_req = 1'b1; d_req = 1'b1;
      #1;
      check("rst_if_gnt", 32'(if_gnt), 32'd0);
      check("rst_d_gnt", 32'(d_gnt), 32'd0);
      if_req = 1'b0; d_req = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      // IF read of preloaded word 0x000
      cyc(1, 12'h000, 0, 0, 12'h000, 16'h0, ig, dg);
      check("if0_gnt", 32'(ig), 32'd1);
      check("if0_rvalid", 32'(if_rvalid), 32'd1);
      check("if0_d_rvalid", 32'(d_rvalid), 32'd0);
      check("if0_rdata", 32'(if_rdata), 32'(16'(16'h0003)));
      // D write then read back
      cyc(0, 12'h000, 1, 1, 12'h010, 16'h1234, ig, dg);
      check("dw_gnt", 32'(dg), 32'd1);
      check("dw_no_rvalid", 32'(d_rvalid), 32'd0);
      cyc(0, 12'h000, 1, 0, 12'h010, 16'h0, ig, dg);
      check("dr_gnt", 32'(dg), 32'd1);
      check("dr_rvalid", 32'(d_rvalid), 32'd1);
      check("dr_rdata", 32'(d_rdata), 32'h1234);
      cyc(0, 12'h000, 0, 0, 12'h000, 16'h0, ig, dg);
      check("dr_pulse", 32'(d_rvalid), 32'd0);
      // Starvation: D wins 4 times, then IF once, repeating
      for (int i = 0; i < 10; i++) begin
         cyc(1, 12'(i), 1, 0, 12'(i + 8), 16'h0, ig, dg);
         check("starve_if", 32'(ig), 32'(i % 5 == 4));
         check("starve_d", 32'(dg), 32'(i % 5 != 4));
      end
      cyc(0, 12'h000, 0, 0, 12'h000, 16'h0, ig, dg);
      check("d_rdata_hold", 32'(d_rdata), 32'(mdl[12'd16]));
      // Collision: D write wins, IF retries and sees the new word
      cyc(1, 12'h020, 1, 1, 12'h020, 16'hBEEF, ig, dg);
      check("col_d_gnt", 32'(dg), 32'd1);
      check("col_if_wait", 32'(ig), 32'd0);
      cyc(1, 12'h020, 0, 0, 12'h000, 16'h0, ig, dg);
      check("col_if_gnt", 32'(ig), 32'd1);
      check("col_if_rdata", 32'(if_rdata), 32'hBEEF);
      cyc(0, 12'h000, 0, 0, 12'h000, 16'h0, ig, dg);
      // Reset while a read is granted
      if_req = 1'b1; if_addr = 12'h040; d_req = 1'b0;
      #1;
      check("rstmid_gnt", 32'(if_gnt), 32'd1);
      rst = 1'b1;
      #1;
      check("rstmid_forced", 32'(if_gnt), 32'd0);
      @(posedge clk); #1;
      check("rstmid_rvalid", 32'(if_rvalid), 32'd0);
      check("rstmid_rdata", 32'(if_rdata), 32'd0);
      if_req = 1'b0; rst = 1'b0;
      @(posedge clk); #1;
      cyc(1, 12'h040, 0, 0, 12'h000, 16'h0, ig, dg);
      check("post_rst_gnt", 32'(ig), 32'd1);
      check("post_rst_rdata", 32'(if_rdata), 32'(mdl[12'h040]));
      // Mixed random traffic on a small address window
      for (int i = 0; i < 300; i++)
         cyc(1'($urandom_range(0, 1)), 12'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 12'($urandom_range(0, 15)), 16'($urandom), ig, dg);
      cyc(0, 12'h000, 0, 0, 12'h000, 16'h0, ig, dg);
`ifdef RAM_PARITY_EN
      cyc(0, 12'h000, 1, 1, 12'h005, 16'h0001, ig, dg);
      dut.mem[5][16] = ~dut.mem[5][16];
      bad[5] = 1'b1;
      cyc(0, 12'h000, 1, 0, 12'h005, 16'h0, ig, dg);
      check("par_bad_rvalid", 32'(d_rvalid), 32'd1);
      check("par_bad_err", 32'(par_err), 32'd1);
      check("par_bad_rdata", 32'(d_rdata), 32'h0001);
      cyc(0, 12'h000, 1, 0, 12'h010, 16'h0, ig, dg);
      check("par_clean_err", 32'(par_err), 32'd0);
      cyc(0, 12'h000, 0, 0, 12'h000, 16'h0, ig, dg);
`endif
      cyc(0, 12'h000, 0, 0, 12'h000, 16'h0, ig, dg);
      check("if_drain", 32'(ifq.size()), 32'd0);
      check("d_drain", 32'(dq.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/ram_arb_dp.md
Name: ram_arb_dp

Overview:
- Parametrised successor to the team's single-port program/data BRAM.
- One block-RAM array shared by two requesters: the instruction-fetch port (IF) and the load/store data port (D).
- Per-cycle arbitration with starvation protection, valid/gnt handshake, and one-cycle registered read latency.
- Sits between the CPU core and the unified program/data memory.

Parameters:
DATA_W  16  word width in bits
ADDR_W  12  address width; depth = 2**ADDR_W words
STARVE_MAX  4  consecutive IF denials before IF is forced to win (1..15)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
if_req  in  1  fetch read request
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  fetch request accepted this cycle (combinational)
if_rvalid  out  1  fetch read data valid (1-cycle pulse)
if_rdata  out  DATA_W  fetch read data
d_req  in  1  data request
d_we  in  1  1 = write, 0 = read (qualified by d_req)
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  write data
d_gnt  out  1  data request accepted this cycle (combinational)
d_rvalid  out  1  data read data valid (1-cycle pulse)
d_rdata  out  DATA_W  data read data
par_err  out  1  parity error on the current rvalid beat (present only with RAM_PARITY_EN)

Behaviour:
- Reset (rst = 1 at posedge):
  - if_rvalid, d_rvalid, if_rdata, d_rdata, par_err cleared to 0.
  - Starvation counter cleared to 0.
  - RAM contents are not cleared.
  - gnt outputs are forced 0 while rst = 1.
- Arbitration, combinational, one access per cycle:
  - Only d_req: d_gnt = 1.
  - Only if_req: if_gnt = 1.
  - Both: D wins unless starve_cnt == STARVE_MAX, then IF wins.
  - Never both gnt high.
- Starvation counter (4 bits):
  - Increments when if_req = 1 and if_gnt = 0.
  - Clears when if_gnt = 1 or if_req = 0.
  - Saturates at STARVE_MAX.
- Requester rule: a requester holds req/addr/wdata stable until it sees gnt; dropping req before gnt is legal (request withdrawn, no side effect).
- Granted write (d_we = 1): array[d_addr] <= d_wdata at that edge; no rvalid.
- Granted read: array read at the grant edge. Next cycle:
  - Port's rvalid = 1 for exactly one cycle.
  - Port's rdata = word.
  - rdata holds that value until the port's next read completes.
- Read latency: 1 cycle from grant to rvalid. Back-to-back grants give back-to-back rvalid pulses, full throughput.
- Read-after-write ordering:
  - D write at cycle N, then any read of the same address granted at N+1 or later, returns the new data.
  - Same-cycle D-write / IF-read collision is impossible (single grant); the IF read retries and sees new data.
- Address wraps by truncation to ADDR_W bits; no out-of-range case.
- d_we is ignored when d_req = 0.
- rst asserted mid-operation: a read granted in the cycle before the reset edge produces no rvalid (suppressed by reset).

Optional Feature:
- Macro: RAM_PARITY_EN.
- Defined:
  - Array is DATA_W+1 bits wide; extra bit is even parity over wdata, written on each write.
  - On each rvalid beat, par_err = 1 if the stored parity mismatches the data (one cycle, aligned with rvalid).
  - par_err resets to 0.
  - rdata is still delivered unmodified.
- Undefined:
  - Array is DATA_W bits; par_err port absent; no parity logic.

Test Plan:
- Reset, then IF read of 0x000 only: if_gnt = 1 same cycle; if_rvalid = 1 next cycle with the preloaded word; d_rvalid stays 0.
- D write 0x1234 @ 0x010, then D read 0x010 the next cycle: d_gnt both cycles; d_rvalid one cycle later with d_rdata = 0x1234.
- Starvation: if_req and d_req (reads) held high continuously from reset, STARVE_MAX = 4 -> d_gnt for 4 cycles, if_gnt in cycle 5, counter clears, pattern repeats.
- Collision: cycle N D write 0xBEEF @ 0x020 with IF read 0x020 pending -> D granted at N; IF granted at N+1; if_rdata = 0xBEEF at N+2.
- Reset mid-read: IF read granted at cycle N, rst = 1 at N+1 edge -> if_rvalid = 0 at N+1, if_rdata = 0; normal operation after rst is released.
- RAM_PARITY_EN: write 0x0001 @ 0x005, then backdoor-flip the stored parity bit and read 0x005 -> d_rvalid = 1, par_err = 1 same cycle, d_rdata = 0x0001. Read a clean word -> par_err = 0.
